// File: rtl/reg_f_pkg.sv
// Shared constants for the reg_f register-file family: fixed register addresses
// and the first register that belongs to a saved context frame.
package reg_f_pkg;

  localparam int RF_ADDR_ZERO   = 0;
  localparam int RF_ADDR_ONES   = 1;
  localparam int RF_ADDR_ACC    = 2;
  localparam int RF_FIRST_SAVED = 2;

endpackage

// File: rtl/rf_ctx_stack.sv
// Context frame stack: CTX_DEPTH frames of the flattened working set, a level
// counter with full/empty status and sticky overflow/underflow flags.
module rf_ctx_stack
  import reg_f_pkg::*;
#(
  parameter int FW        = 72,
  parameter int CTX_DEPTH = 4,
  parameter int LW        = $clog2(CTX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  input  logic [FW-1:0] frame_in,
  output logic [FW-1:0] frame_out,
  output logic          restore,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam int IW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

  logic [FW-1:0] mem [CTX_DEPTH];
  logic          push_only;
  logic          pop_only;
  logic          do_push;
  logic [LW-1:0] level_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Simultaneous push and pop cancel each other and raise no error.
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign full      = (level == LW'(CTX_DEPTH));
  assign empty     = (level == '0);
  assign do_push   = push_only & ~full;
  assign restore   = pop_only & ~empty & ~rst;

  assign level_m1  = level - LW'(1);
  assign wr_idx    = level[IW-1:0];
  assign rd_idx    = level_m1[IW-1:0];
  assign frame_out = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_idx] <= frame_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (do_push) begin
        level <= level + LW'(1);
      end else if (pop_only && !empty) begin
        level <= level_m1;
      end
      // A fresh error event outranks a clear in the same cycle.
      ovf <= (ovf & ~err_clr) | (push_only & full);
      unf <= (unf & ~err_clr) | (pop_only & empty);
    end
  end

endmodule

// File: rtl/reg_f_ctx.sv
// CPU register file with hard constants at 0/1, ACC at 2 and a clocked context
// stack that saves/restores ACC plus the work registers for nested calls/IRQs.
module reg_f_ctx
  import reg_f_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 11,
  parameter int CTX_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(SIZE)-1:0]        rf_addr_r1,
  output logic [WIDTH-1:0]               rf_data_out1,
  input  logic [$clog2(SIZE)-1:0]        rf_addr_r2,
  output logic [WIDTH-1:0]               rf_data_out2,
  input  logic [$clog2(SIZE)-1:0]        rf_addr_wr,
  input  logic                           rf_data_we,
  input  logic [WIDTH-1:0]               rf_data_in,
  input  logic                           rf_stack_push,
  input  logic                           rf_stack_pop,
  input  logic                           rf_err_clr,
  output logic [$clog2(CTX_DEPTH+1)-1:0] rf_stack_level,
  output logic                           rf_stack_full,
  output logic                           rf_stack_empty,
  output logic                           rf_stack_ovf,
  output logic                           rf_stack_unf,
  output logic                           rf_acc_zero
);

  localparam int AW    = $clog2(SIZE);
  localparam int LW    = $clog2(CTX_DEPTH + 1);
  localparam int NSAVE = SIZE - RF_FIRST_SAVED;
  localparam int FW    = NSAVE * WIDTH;

  // regs[i] holds architectural register i + RF_FIRST_SAVED.
  logic [WIDTH-1:0] regs [NSAVE];
  logic [FW-1:0]    frame_save;
  logic [FW-1:0]    frame_restore;
  logic             restore;

  function automatic logic [WIDTH-1:0] read_reg(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    if (addr == AW'(RF_ADDR_ONES)) begin
      val = '1;
    end
    for (int i = 0; i < NSAVE; i++) begin
      if (addr == AW'(i + RF_FIRST_SAVED)) begin
        val = regs[i];
      end
    end
    return val;
  endfunction

  assign rf_data_out1 = read_reg(rf_addr_r1);
  assign rf_data_out2 = read_reg(rf_addr_r2);
  assign rf_acc_zero  = (regs[RF_ADDR_ACC - RF_FIRST_SAVED] == '0);

  always_comb begin
    frame_save = '0;
    for (int i = 0; i < NSAVE; i++) begin
      frame_save[i*WIDTH +: WIDTH] = regs[i];
    end
  end

  rf_ctx_stack #(
    .FW        (FW),
    .CTX_DEPTH (CTX_DEPTH),
    .LW        (LW)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (rf_stack_push),
    .pop       (rf_stack_pop),
    .err_clr   (rf_err_clr),
    .frame_in  (frame_save),
    .frame_out (frame_restore),
    .restore   (restore),
    .level     (rf_stack_level),
    .full      (rf_stack_full),
    .empty     (rf_stack_empty),
    .ovf       (rf_stack_ovf),
    .unf       (rf_stack_unf)
  );

  // A restoring pop overwrites the whole working set, so a same-cycle write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSAVE; i++) begin
        regs[i] <= '0;
      end
    end else if (restore) begin
      for (int i = 0; i < NSAVE; i++) begin
        regs[i] <= frame_restore[i*WIDTH +: WIDTH];
      end
    end else if (rf_data_we) begin
      for (int i = 0; i < NSAVE; i++) begin
        if (rf_addr_wr == AW'(i + RF_FIRST_SAVED)) begin
          regs[i] <= rf_data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_f_ctx.sv
// Self-checking bench for reg_f_ctx: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of registers and stack.
module tb_reg_f_ctx;

  localparam int WIDTH     = 8;
  localparam int SIZE      = 11;
  localparam int CTX_DEPTH = 4;
  localparam int AW        = $clog2(SIZE);
  localparam int LW        = $clog2(CTX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    rf_addr_r1, rf_addr_r2, rf_addr_wr;
  logic [WIDTH-1:0] rf_data_out1, rf_data_out2, rf_data_in;
  logic             rf_data_we, rf_stack_push, rf_stack_pop, rf_err_clr;
  logic [LW-1:0]    rf_stack_level;
  logic             rf_stack_full, rf_stack_empty, rf_stack_ovf, rf_stack_unf;
  logic             rf_acc_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_f_ctx #(.WIDTH(WIDTH), .SIZE(SIZE), .CTX_DEPTH(CTX_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .rf_addr_r1     (rf_addr_r1),
    .rf_data_out1   (rf_data_out1),
    .rf_addr_r2     (rf_addr_r2),
    .rf_data_out2   (rf_data_out2),
    .rf_addr_wr     (rf_addr_wr),
    .rf_data_we     (rf_data_we),
    .rf_data_in     (rf_data_in),
    .rf_stack_push  (rf_stack_push),
    .rf_stack_pop   (rf_stack_pop),
    .rf_err_clr     (rf_err_clr),
    .rf_stack_level (rf_stack_level),
    .rf_stack_full  (rf_stack_full),
    .rf_stack_empty (rf_stack_empty),
    .rf_stack_ovf   (rf_stack_ovf),
    .rf_stack_unf   (rf_stack_unf),
    .rf_acc_zero    (rf_acc_zero)
  );

  // Behavioural model: architectural registers plus a LIFO of saved frames.
  typedef logic [SIZE-3:0][WIDTH-1:0] frame_t;
  logic [WIDTH-1:0] mr [SIZE];
  frame_t           stk[$];
  bit               m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (a == 1) return '1;
    if (a < SIZE) return mr[a];
    return '0;
  endfunction

  task automatic model_step();
    frame_t cur;
    bit     push_v, pop_v, did_pop;
    bit     new_ovf, new_unf;
    if (rst) begin
      for (int i = 0; i < SIZE; i++) mr[i] = '0;
      stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      push_v  = rf_stack_push && !rf_stack_pop;
      pop_v   = rf_stack_pop && !rf_stack_push;
      new_ovf = push_v && (stk.size() == CTX_DEPTH);
      new_unf = pop_v && (stk.size() == 0);
      did_pop = 0;
      for (int i = 2; i < SIZE; i++) cur[i-2] = mr[i];
      if (push_v && !new_ovf) stk.push_back(cur);
      if (pop_v && !new_unf) begin
        cur = stk.pop_back();
        for (int i = 2; i < SIZE; i++) mr[i] = cur[i-2];
        did_pop = 1;
      end
      if (rf_data_we && !did_pop && int'(rf_addr_wr) >= 2 && int'(rf_addr_wr) < SIZE)
        mr[rf_addr_wr] = rf_data_in;
      if (rf_err_clr) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (new_ovf) m_ovf = 1;
      if (new_unf) m_unf = 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    rf_data_we    = 1'b0;
    rf_stack_push = 1'b0;
    rf_stack_pop  = 1'b0;
    rf_err_clr    = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    rf_addr_wr = AW'(a);
    rf_data_in = WIDTH'(d);
    rf_data_we = 1'b1;
    cycle();
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp);
    rf_addr_r1 = AW'(a);
    rf_addr_r2 = AW'(a);
    #1;
    chk({tag, "_r1"}, 32'(rf_data_out1), 32'(exp));
    chk({tag, "_r2"}, 32'(rf_data_out2), 32'(exp));
  endtask

  task automatic model_chk(input string tag);
    chk({tag, "_level"}, 32'(rf_stack_level), 32'(stk.size()));
    chk({tag, "_full"},  32'(rf_stack_full),  32'(stk.size() == CTX_DEPTH));
    chk({tag, "_empty"}, 32'(rf_stack_empty), 32'(stk.size() == 0));
    chk({tag, "_ovf"},   32'(rf_stack_ovf),   32'(m_ovf));
    chk({tag, "_unf"},   32'(rf_stack_unf),   32'(m_unf));
    chk({tag, "_accz"},  32'(rf_acc_zero),    32'(mr[2] == '0));
  endtask

  initial begin
    rst = 1'b1;
    rf_addr_r1 = '0; rf_addr_r2 = '0; rf_addr_wr = '0;
    rf_data_in = '0; rf_data_we = 1'b0;
    rf_stack_push = 1'b0; rf_stack_pop = 1'b0; rf_err_clr = 1'b0;
    for (int i = 0; i < SIZE; i++) mr[i] = '0;
    m_ovf = 0; m_unf = 0;

    // 1: reset state
    rst = 1'b1; cycle();
    rd_chk("rst_a0", 0, 'h00);
    rd_chk("rst_a1", 1, 'hFF);
    rd_chk("rst_acc", 2, 'h00);
    chk("rst_accz", 32'(rf_acc_zero), 1);
    chk("rst_empty", 32'(rf_stack_empty), 1);
    chk("rst_full", 32'(rf_stack_full), 0);
    chk("rst_level", 32'(rf_stack_level), 0);

    // 2: save / modify / restore
    wr(2, 'h5A); wr(3, 'h11);
    rf_stack_push = 1'b1; cycle();
    chk("t2_level1", 32'(rf_stack_level), 1);
    wr(2, 'h00); wr(3, 'h22);
    chk("t2_accz_mod", 32'(rf_acc_zero), 1);
    rf_stack_pop = 1'b1; cycle();
    rd_chk("t2_acc", 2, 'h5A);
    rd_chk("t2_r0", 3, 'h11);
    chk("t2_accz", 32'(rf_acc_zero), 0);
    chk("t2_level0", 32'(rf_stack_level), 0);

    // 3: overflow and underflow
    for (int i = 1; i <= 5; i++) begin
      wr(2, i);
      rf_stack_push = 1'b1; cycle();
    end
    chk("t3_level", 32'(rf_stack_level), 4);
    chk("t3_full", 32'(rf_stack_full), 1);
    chk("t3_ovf", 32'(rf_stack_ovf), 1);
    for (int i = 4; i >= 1; i--) begin
      rf_stack_pop = 1'b1; cycle();
      rd_chk($sformatf("t3_pop%0d", i), 2, i);
    end
    chk("t3_empty", 32'(rf_stack_empty), 1);
    rf_stack_pop = 1'b1; cycle();
    chk("t3_unf", 32'(rf_stack_unf), 1);
    rd_chk("t3_acc_after_unf", 2, 1);

    // 4: same-cycle interactions
    rf_err_clr = 1'b1; cycle();
    chk("t4_clr_ovf", 32'(rf_stack_ovf), 0);
    chk("t4_clr_unf", 32'(rf_stack_unf), 0);
    wr(2, 'h10);
    rf_stack_push = 1'b1; rf_data_we = 1'b1; rf_addr_wr = 2; rf_data_in = 'h33; cycle();
    rd_chk("t4_acc_written", 2, 'h33);
    rf_stack_pop = 1'b1; cycle();
    rd_chk("t4_acc_restored", 2, 'h10);
    rf_stack_push = 1'b1; rf_stack_pop = 1'b1; cycle();
    chk("t4_pp_level", 32'(rf_stack_level), 0);
    chk("t4_pp_ovf", 32'(rf_stack_ovf), 0);
    chk("t4_pp_unf", 32'(rf_stack_unf), 0);

    // 5: constants and read-during-write
    wr(0, 'hAB); wr(1, 'h00);
    rd_chk("t5_a0", 0, 'h00);
    rd_chk("t5_a1", 1, 'hFF);
    rd_chk("t5_oor", 13, 'h00);
    wr(3, 'h77);
    rf_data_we = 1'b1; rf_addr_wr = 3; rf_data_in = 'h99;
    rd_chk("t5_rdw_old", 3, 'h77);
    cycle();
    rd_chk("t5_rdw_new", 3, 'h99);

    // 6: reset in the middle of a nested context
    rf_stack_push = 1'b1; cycle();
    rf_stack_push = 1'b1; cycle();
    chk("t6_level2", 32'(rf_stack_level), 2);
    rst = 1'b1; rf_stack_pop = 1'b1; cycle();
    chk("t6_level0", 32'(rf_stack_level), 0);
    rd_chk("t6_acc", 2, 'h00);
    rd_chk("t6_r0", 3, 'h00);
    chk("t6_ovf", 32'(rf_stack_ovf), 0);
    chk("t6_unf", 32'(rf_stack_unf), 0);
    rf_stack_pop = 1'b1; cycle();
    chk("t6_unf_after", 32'(rf_stack_unf), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 79) == 0);
      rf_data_we    = $urandom_range(0, 1);
      rf_addr_wr    = AW'($urandom_range(0, 15));
      rf_data_in    = WIDTH'($urandom);
      rf_stack_push = ($urandom_range(0, 3) == 0);
      rf_stack_pop  = ($urandom_range(0, 3) == 0);
      rf_err_clr    = ($urandom_range(0, 9) == 0);
      rf_addr_r1    = AW'($urandom_range(0, 15));
      rf_addr_r2    = AW'($urandom_range(0, 15));
      #1;
      chk("rnd_r1", 32'(rf_data_out1), 32'(exp_rd(int'(rf_addr_r1))));
      chk("rnd_r2", 32'(rf_data_out2), 32'(exp_rd(int'(rf_addr_r2))));
      cycle();
      model_chk("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
